// File: rtl/stage_monitor_pkg.sv
// Shared types for stage_monitor: channel state encoding, event kinds and the
// event record carried through the event FIFO.
package stage_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } chan_state_e;

  typedef enum logic [1:0] {
    EVT_CHANGE  = 2'd0,
    EVT_PASS    = 2'd1,
    EVT_FAIL    = 2'd2,
    EVT_TIMEOUT = 2'd3
  } evt_kind_e;

  localparam int unsigned CHAN_W      = 3;
  // Widest stage code an event record can carry; narrower codes are zero-extended.
  localparam int unsigned STAGE_W_MAX = 16;

  typedef struct packed {
    logic [CHAN_W-1:0]      chan;
    logic [STAGE_W_MAX-1:0] stage;
    evt_kind_e              kind;
  } evt_t;

  function automatic logic is_terminal(chan_state_e s);
    return s inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
  endfunction

endpackage

// File: rtl/stage_monitor_fifo.sv
// Synchronous event FIFO (DEPTH must be a power of two, >= 2) with a
// valid/ready read side, a full flag and a synchronous flush.
module stage_monitor_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop;
  logic             wr_en;

  assign valid = (wr_ptr != rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stage_monitor.sv
// Multi-channel test-progress monitor: samples stage codes/error flags every
// SAMPLE_DIV cycles, runs a per-channel IDLE/RUN/PASS/FAIL/TIMEOUT machine and
// queues stage-change events. Define STAGE_MON_SYNC_EN to add 2-flop input
// synchronizers for asynchronous stage/error inputs.
module stage_monitor
  import stage_monitor_pkg::*;
#(
  parameter int unsigned         CHANNELS   = 2,
  parameter int unsigned         STAGE_W    = 8,
  parameter logic [STAGE_W-1:0]  START_CODE = {STAGE_W{1'b1}},
  parameter logic [STAGE_W-1:0]  PASS_CODE  = {{(STAGE_W-1){1'b1}}, 1'b0},
  parameter int unsigned         SAMPLE_DIV = 100,
  parameter int unsigned         TIMEOUT_W  = 16,
  parameter int unsigned         FIFO_DEPTH = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [CHANNELS*STAGE_W-1:0] stage_i,
  input  logic [CHANNELS-1:0]         error_i,
  input  logic [TIMEOUT_W-1:0]        timeout_limit_i,
  input  logic                        clear_i,
  output logic [CHANNELS*3-1:0]       state_o,
  output logic                        all_done_o,
  output logic                        all_pass_o,
  output logic                        any_fail_o,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [2:0]                  evt_chan_o,
  output logic [STAGE_W-1:0]          evt_stage_o,
  output logic [1:0]                  evt_kind_o,
  output logic                        overflow_o
);

  localparam int unsigned          DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]     DIV_ONE  = DIV_W'(1);
  localparam logic [TIMEOUT_W-1:0] TCNT_ONE = TIMEOUT_W'(1);

  logic [DIV_W-1:0]            div_cnt;
  logic                        tick;
  logic [CHANNELS*STAGE_W-1:0] stage_s;
  logic [CHANNELS-1:0]         error_s;
  logic [STAGE_W-1:0]          samp [CHANNELS];

  chan_state_e          state_q      [CHANNELS];
  chan_state_e          state_n      [CHANNELS];
  logic [TIMEOUT_W-1:0] tcnt_q       [CHANNELS];
  logic [TIMEOUT_W-1:0] tcnt_n       [CHANNELS];
  logic [STAGE_W-1:0]   last_q       [CHANNELS];
  evt_kind_e            kind_n       [CHANNELS];
  logic [CHANNELS-1:0]  fire;
  logic [CHANNELS-1:0]  pend_q;
  evt_kind_e            pend_kind_q  [CHANNELS];
  logic [STAGE_W-1:0]   pend_stage_q [CHANNELS];

  logic [CHANNELS-1:0] grant;
  logic                found;
  logic                push;
  evt_t                push_evt;
  evt_t                head;
  logic                fifo_full;
  logic                evt_valid;
  logic                drop;
  logic                overflow_q;

  // Divider keeps running through clear_i so the sample grid never shifts.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_ONE;
  end

`ifdef STAGE_MON_SYNC_EN
  logic [CHANNELS*STAGE_W-1:0] stage_m1;
  logic [CHANNELS*STAGE_W-1:0] stage_m2;
  logic [CHANNELS-1:0]         error_m1;
  logic [CHANNELS-1:0]         error_m2;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stage_m1 <= '0;
      stage_m2 <= '0;
      error_m1 <= '0;
      error_m2 <= '0;
    end else begin
      stage_m1 <= stage_i;
      stage_m2 <= stage_m1;
      error_m1 <= error_i;
      error_m2 <= error_m1;
    end
  end

  assign stage_s = stage_m2;
  assign error_s = error_m2;
`else
  assign stage_s = stage_i;
  assign error_s = error_i;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign samp[g]          = stage_s[g*STAGE_W +: STAGE_W];
    assign state_o[g*3 +: 3] = state_q[g];
  end

  // Next state per channel; only committed on a sample tick.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_n[i] = state_q[i];
      tcnt_n[i]  = tcnt_q[i];
      fire[i]    = 1'b0;
      kind_n[i]  = EVT_CHANGE;
      case (state_q[i])
        ST_IDLE: begin
          if (error_s[i]) begin
            state_n[i] = ST_FAIL;
            fire[i]    = 1'b1;
            kind_n[i]  = EVT_FAIL;
          end else if (samp[i] == START_CODE) begin
            state_n[i] = ST_RUN;
            tcnt_n[i]  = '0;
            fire[i]    = 1'b1;
          end
        end
        ST_RUN: begin
          if (error_s[i]) begin
            state_n[i] = ST_FAIL;
            fire[i]    = 1'b1;
            kind_n[i]  = EVT_FAIL;
          end else if (samp[i] == PASS_CODE) begin
            state_n[i] = ST_PASS;
            fire[i]    = 1'b1;
            kind_n[i]  = EVT_PASS;
          end else if (samp[i] != last_q[i]) begin
            tcnt_n[i] = '0;
            fire[i]   = 1'b1;
          end else begin
            tcnt_n[i] = tcnt_q[i] + TCNT_ONE;
            if ((timeout_limit_i != '0) && (tcnt_q[i] + TCNT_ONE == timeout_limit_i)) begin
              state_n[i] = ST_TIMEOUT;
              fire[i]    = 1'b1;
              kind_n[i]  = EVT_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A new event on the tick wins over the grant that retires the previous one.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear_i) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state_q[i]      <= ST_IDLE;
        tcnt_q[i]       <= '0;
        last_q[i]       <= '0;
        pend_q[i]       <= 1'b0;
        pend_kind_q[i]  <= EVT_CHANGE;
        pend_stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (grant[i]) pend_q[i] <= 1'b0;
        if (tick) begin
          state_q[i] <= state_n[i];
          tcnt_q[i]  <= tcnt_n[i];
          last_q[i]  <= samp[i];
          if (fire[i]) begin
            pend_q[i]       <= 1'b1;
            pend_kind_q[i]  <= kind_n[i];
            pend_stage_q[i] <= samp[i];
          end
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    push_evt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pend_q[i] && !found) begin
        found          = 1'b1;
        grant[i]       = 1'b1;
        push_evt.chan  = CHAN_W'(i);
        push_evt.stage = STAGE_W_MAX'(pend_stage_q[i]);
        push_evt.kind  = pend_kind_q[i];
      end
    end
  end

  assign push = found;
  assign drop = push && fifo_full && !(evt_valid && evt_ready_i);

  stage_monitor_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (clear_i),
    .push  (push),
    .din   (push_evt),
    .full  (fifo_full),
    .valid (evt_valid),
    .ready (evt_ready_i),
    .dout  (head)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clear_i) overflow_q <= 1'b0;
    else if (drop)           overflow_q <= 1'b1;
  end

  assign overflow_o  = overflow_q;
  assign evt_valid_o = evt_valid;
  assign evt_chan_o  = evt_valid ? head.chan : '0;
  assign evt_stage_o = evt_valid ? STAGE_W'(head.stage) : '0;
  assign evt_kind_o  = evt_valid ? head.kind : '0;

  always_comb begin
    all_done_o = 1'b1;
    all_pass_o = 1'b1;
    any_fail_o = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!is_terminal(state_q[i])) all_done_o = 1'b0;
      if (state_q[i] != ST_PASS)    all_pass_o = 1'b0;
      if (state_q[i] == ST_FAIL || state_q[i] == ST_TIMEOUT) any_fail_o = 1'b1;
    end
  end

endmodule
